pixel_write_arbiter: RTL and testbench
======================================

PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 Parameter SCREEN_W, default 320, sets the horizontal pixel count of the VGA adapter framebuffer.
REQ-002 Parameter SCREEN_H, default 240, sets the vertical pixel count of the VGA adapter framebuffer.
REQ-003 Port clock, input, 1 bit: single system clock (CLOCK_50 domain); all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Ports req0/req1, input, 1 bit each: requester n asks for the plot port.
REQ-006 Ports x0/x1 [8:0], y0/y1 [7:0], colour0/colour1 [2:0], input: pixel offered by requester n.
REQ-007 Ports last0/last1, input, 1 bit each: the offered pixel ends requester n's burst.
REQ-008 Ports gnt0/gnt1, output, 1 bit each, registered: requester n owns the port.
REQ-009 Ports clear_start (input, 1-bit pulse) and clear_colour (input [2:0]): request a full-screen fill.
REQ-010 Port clear_busy, output, 1 bit: sweep in progress; clear_done, output, 1-cycle pulse: sweep finished.
REQ-011 Ports plot (1), x [8:0], y [7:0], colour [2:0], output, registered: drive the vga_adapter write port.

Function
REQ-012 FSM states IDLE, GRANT0, GRANT1, CLEAR; gntN SHALL be high exactly while in GRANTN.
REQ-013 Pixel accepted on a cycle where reqN && gntN; plot/x/y/colour SHALL reflect it on the next cycle (latency 1); otherwise plot=0 and x/y/colour hold.
REQ-014 IDLE priority: clear_pending first -> CLEAR; else a single requester -> its GRANT; both requesting -> the one not equal to last_served.
REQ-015 GRANTN -> IDLE after an accepted pixel with lastN=1, setting last_served=N; one idle bubble before re-arbitration.
REQ-016 GRANTN -> IDLE if reqN is low while granted (abandoned burst); last_served=N.
REQ-017 No preemption: a burst in progress SHALL never be interrupted by the other requester or by clear.
REQ-018 clear_start sets clear_pending and latches clear_colour; clear_start while clear_pending or CLEAR SHALL be ignored (colour not re-latched).
REQ-019 CLEAR emits one pixel per cycle, raster order: x 0..SCREEN_W-1, wrap to 0 with y+1, from (0,0) to (SCREEN_W-1,SCREEN_H-1); exactly SCREEN_W*SCREEN_H plot pulses.
REQ-020 After issuing the final pixel, CLEAR -> IDLE; clear_done pulses on the cycle the final plot is on the outputs; clear_pending and clear_busy clear on that same cycle.
REQ-021 clear_busy SHALL be high from the cycle after clear_start until clear_done, inclusive of waiting for a burst to end.
REQ-022 Coordinates from requesters pass unmodified (no clipping); sweep counters are 9-bit x and 8-bit y, never exceeding SCREEN_W-1/SCREEN_H-1.
REQ-023 Simultaneous clear_start and reqN in IDLE: the clear SHALL win on the following arbitration (pending set, then CLEAR).

Reset
REQ-024 On reset: state IDLE, gnt0=gnt1=0, plot=0, x=0, y=0, colour=0, clear_busy=0, clear_done=0, clear_pending=0, last_served=1 (requester 0 wins the first tie).
REQ-025 Reset mid-sweep or mid-burst SHALL abort immediately with no clear_done pulse and no further plot.

Structure
REQ-026 Shared package vga_arb_pkg SHALL hold the state encoding, SCREEN_W/SCREEN_H defaults and coordinate/colour widths (9/8/3).
REQ-027 The raster counter SHALL be one sub-module, clear_sweeper (inputs clock, reset, start, advance; outputs x, y, last_pixel).

Verification
REQ-028 Reset, then req0=1 with (x0=10,y0=20,colour0=3'b101,last0=1) -> gnt0 next cycle; plot=1, x=10, y=20, colour=5 one cycle after accept; gnt0 low after.
REQ-029 req0 and req1 both held, last=1 each pixel -> grants alternate 0,1,0,1 with one IDLE bubble between grants.
REQ-030 req1 burst of 4 pixels (last1 on 4th), clear_start on 2nd pixel -> all 4 pixels plotted, then CLEAR; clear_busy high throughout.
REQ-031 clear_start with clear_colour=3'b010 while idle -> 76800 consecutive plot pulses, first (0,0), (319,0) followed by (0,1), last (319,239), colour 2; clear_done single pulse aligned with last plot.
REQ-032 Reset asserted at sweep pixel 1000 -> plot=0 next cycle, clear_busy=0, no clear_done; subsequent req0 served normally.
REQ-033 req0 granted then dropped without last0 -> gnt0 falls, IDLE, pending req1 granted next arbitration.

Source files
------------

// File: rtl/vga_arb_pkg.sv
// Shared definitions for the framebuffer write arbiter: screen geometry
// defaults, coordinate/colour widths, FSM state encoding and the pixel bundle.
package vga_arb_pkg;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

    function automatic pixel_t make_pixel(input logic [X_W-1:0] x,
                                          input logic [Y_W-1:0] y,
                                          input logic [C_W-1:0] colour);
        pixel_t p;
        p.x      = x;
        p.y      = y;
        p.colour = colour;
        return p;
    endfunction

endpackage

// File: rtl/clear_sweeper.sv
// Raster-order coordinate generator for the full-screen fill.
// start rewinds to (0,0); advance steps x, wrapping to the next line at the
// right edge and back to (0,0) after the bottom-right pixel.
module clear_sweeper
    import vga_arb_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last_pixel
);

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    // Next raster position: rewind on start, otherwise step on advance.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign last_pixel = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/pixel_write_arbiter.sv
// Two-requester arbiter for the vga_adapter plot port, with a built-in
// full-screen clear sweep. Bursts are never preempted; a clear request waits
// for the current burst to finish, then owns the port for one whole frame.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | nobody owns the port; arbitrate (clear first, then round-robin)
//   GRANT0 | requester 0 owns the port until last0 or req0 drops
//   GRANT1 | requester 1 owns the port until last1 or req1 drops
//   CLEAR  | sweeper owns the port, one fill pixel per cycle
module pixel_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req0,
    input  logic           req1,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [C_W-1:0] colour0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  logic [C_W-1:0] colour1,
    input  logic           last0,
    input  logic           last1,
    output logic           gnt0,
    output logic           gnt1,
    input  logic           clear_start,
    input  logic [C_W-1:0] clear_colour,
    output logic           clear_busy,
    output logic           clear_done,
    output logic           plot,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] colour
);

    logic [1:0]     state_q, state_d;
    logic           last_served_q, last_served_d;
    logic           clear_pending_q, clear_pending_d;
    logic [C_W-1:0] clear_colour_q, clear_colour_d;
    logic           plot_q, plot_d;
    pixel_t         pix_q, pix_d;
    logic           clear_done_q, clear_done_d;
    logic           gnt0_q, gnt1_q;

    logic           start_ok;
    logic           sweep_start;
    logic           sweep_advance;
    logic [X_W-1:0] sweep_x;
    logic [Y_W-1:0] sweep_y;
    logic           sweep_last;

    clear_sweeper #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_sweeper (
        .clock      (clock),
        .reset      (reset),
        .start      (sweep_start),
        .advance    (sweep_advance),
        .x          (sweep_x),
        .y          (sweep_y),
        .last_pixel (sweep_last)
    );

    // Arbitration, burst tracking, clear bookkeeping and next output pixel.
    always_comb begin
        state_d         = state_q;
        last_served_d   = last_served_q;
        clear_pending_d = clear_pending_q;
        clear_colour_d  = clear_colour_q;
        plot_d          = 1'b0;
        pix_d           = pix_q;
        clear_done_d    = 1'b0;
        sweep_advance   = 1'b0;

        // A second clear request while one is outstanding is dropped entirely.
        start_ok = clear_start && !clear_pending_q;
        if (start_ok) begin
            clear_pending_d = 1'b1;
            clear_colour_d  = clear_colour;
        end

        case (state_q)
            ST_IDLE: begin
                // A clear arriving in the same cycle as a request still wins.
                if (clear_pending_q || start_ok) begin
                    state_d = ST_CLEAR;
                end else if (req0 && req1) begin
                    state_d = last_served_q ? ST_GRANT0 : ST_GRANT1;
                end else if (req0) begin
                    state_d = ST_GRANT0;
                end else if (req1) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                if (req0) begin
                    plot_d = 1'b1;
                    pix_d  = make_pixel(x0, y0, colour0);
                end
                if (!req0 || last0) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b0;
                end
            end
            ST_GRANT1: begin
                if (req1) begin
                    plot_d = 1'b1;
                    pix_d  = make_pixel(x1, y1, colour1);
                end
                if (!req1 || last1) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b1;
                end
            end
            default: begin
                plot_d        = 1'b1;
                pix_d         = make_pixel(sweep_x, sweep_y, clear_colour_q);
                sweep_advance = 1'b1;
                if (sweep_last) begin
                    state_d         = ST_IDLE;
                    clear_pending_d = 1'b0;
                    clear_done_d    = 1'b1;
                end
            end
        endcase

        sweep_start = (state_q == ST_IDLE) && (state_d == ST_CLEAR);
    end

    // State, grant and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_served_q   <= 1'b1;
            clear_pending_q <= 1'b0;
            clear_colour_q  <= '0;
            plot_q          <= 1'b0;
            pix_q           <= '0;
            clear_done_q    <= 1'b0;
            gnt0_q          <= 1'b0;
            gnt1_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_served_q   <= last_served_d;
            clear_pending_q <= clear_pending_d;
            clear_colour_q  <= clear_colour_d;
            plot_q          <= plot_d;
            pix_q           <= pix_d;
            clear_done_q    <= clear_done_d;
            gnt0_q          <= (state_d == ST_GRANT0);
            gnt1_q          <= (state_d == ST_GRANT1);
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign clear_busy = clear_pending_q;
    assign clear_done = clear_done_q;
    assign plot       = plot_q;
    assign x          = pix_q.x;
    assign y          = pix_q.y;
    assign colour     = pix_q.colour;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// port-ownership model that tracks the sweep as a flat pixel index.
module tb_pixel_write_arbiter;

    localparam int W = 320;
    localparam int H = 240;

    logic       clock;
    logic       reset;
    logic       req0, req1, last0, last1;
    logic [8:0] x0, x1;
    logic [7:0] y0, y1;
    logic [2:0] colour0, colour1;
    logic       clear_start;
    logic [2:0] clear_colour;
    logic       gnt0, gnt1, clear_busy, clear_done, plot;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;

    int n_cmp = 0;
    int n_bad = 0;

    pixel_write_arbiter #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .x0           (x0),
        .y0           (y0),
        .colour0      (colour0),
        .x1           (x1),
        .y1           (y1),
        .colour1      (colour1),
        .last0        (last0),
        .last1        (last1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: who owns the port (0 none, 1 req0, 2 req1, 3 sweep),
    // who was served last, and the sweep position as a single pixel index.
    int         m_own   = 0;
    bit         m_last  = 1'b1;
    bit         m_pend  = 1'b0;
    logic [2:0] m_ccol  = 3'd0;
    int         m_idx   = 0;
    bit         m_valid = 1'b0;
    logic       e_plot  = 1'b0;
    logic [8:0] e_x     = 9'd0;
    logic [7:0] e_y     = 8'd0;
    logic [2:0] e_c     = 3'd0;
    logic       e_done  = 1'b0;

    always @(posedge clock) begin
        bit s_ok;
        if (reset) begin
            m_own = 0; m_last = 1'b1; m_pend = 1'b0; m_ccol = 3'd0; m_idx = 0;
            e_plot = 1'b0; e_x = 9'd0; e_y = 8'd0; e_c = 3'd0; e_done = 1'b0;
            m_valid = 1'b1;
        end else begin
            s_ok   = clear_start && !m_pend;
            e_plot = 1'b0;
            e_done = 1'b0;
            case (m_own)
                0: begin
                    if (m_pend || s_ok) begin
                        m_own = 3;
                        m_idx = 0;
                    end else if (req0 && (!req1 || m_last)) m_own = 1;
                    else if (req1) m_own = 2;
                end
                1: begin
                    if (req0) begin e_plot = 1'b1; e_x = x0; e_y = y0; e_c = colour0; end
                    if (!req0 || last0) begin m_own = 0; m_last = 1'b0; end
                end
                2: begin
                    if (req1) begin e_plot = 1'b1; e_x = x1; e_y = y1; e_c = colour1; end
                    if (!req1 || last1) begin m_own = 0; m_last = 1'b1; end
                end
                default: begin
                    e_plot = 1'b1;
                    e_x    = 9'(m_idx % W);
                    e_y    = 8'(m_idx / W);
                    e_c    = m_ccol;
                    m_idx  = m_idx + 1;
                    if (m_idx == W * H) begin
                        m_own  = 0;
                        m_pend = 1'b0;
                        e_done = 1'b1;
                    end
                end
            endcase
            if (s_ok) begin
                m_pend = 1'b1;
                m_ccol = clear_colour;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        logic [24:0] act, exp;
        if (m_valid) begin
            act = {plot, gnt0, gnt1, clear_busy, clear_done, x, y, colour};
            exp = {e_plot, (m_own == 1), (m_own == 2), m_pend, e_done, e_x, e_y, e_c};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t got plot=%b g0=%b g1=%b busy=%b done=%b x=%0d y=%0d c=%0d required plot=%b g0=%b g1=%b busy=%b done=%b x=%0d y=%0d c=%0d",
                         $time, plot, gnt0, gnt1, clear_busy, clear_done, x, y, colour,
                         exp[24], exp[23], exp[22], exp[21], exp[20], e_x, e_y, e_c);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        x0 = 9'd0; y0 = 8'd0; colour0 = 3'd0;
        x1 = 9'd0; y1 = 8'd0; colour1 = 3'd0;
        clear_start = 1'b0; clear_colour = 3'd0;
    endtask

    initial begin
        logic [1:0] pat [8];
        int k, dones, gaps, done_at;

        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {plot, gnt0, gnt1, clear_busy, clear_done}, 5'b0);
        chk("reset_pixel", {x, y, colour}, 20'd0);
        reset = 1'b0;
        tick();

        // Single one-pixel burst from requester 0.
        req0 = 1'b1; x0 = 9'd10; y0 = 8'd20; colour0 = 3'b101; last0 = 1'b1;
        tick();
        chk("single_gnt0", gnt0, 1);
        chk("single_no_plot_yet", plot, 0);
        tick();
        chk("single_plot", plot, 1);
        chk("single_x", x, 10);
        chk("single_y", y, 20);
        chk("single_colour", colour, 5);
        chk("single_gnt0_low", gnt0, 0);
        req0 = 1'b0;
        tick();
        chk("single_plot_off", plot, 0);
        chk("single_x_hold", x, 10);

        // Both requesters held, one-pixel bursts: alternation with bubbles.
        tick();
        req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
        x0 = 9'd1; y0 = 8'd2; colour0 = 3'd1; x1 = 9'd300; y1 = 8'd200; colour1 = 3'd7;
        pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("alternate_%0d", i), {gnt0, gnt1}, pat[i]);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) tick();

        // Four-pixel burst from requester 1 with a clear requested mid-burst.
        req1 = 1'b1; last1 = 1'b0; x1 = 9'd100; y1 = 8'd50; colour1 = 3'd3;
        tick();
        chk("burst_gnt1", gnt1, 1);
        tick();
        chk("burst_px0", {plot, x}, {1'b1, 9'd100});
        x1 = 9'd101; clear_start = 1'b1; clear_colour = 3'd6;
        tick();
        clear_start = 1'b0;
        chk("burst_px1", {plot, x}, {1'b1, 9'd101});
        chk("burst_busy1", clear_busy, 1);
        x1 = 9'd102;
        tick();
        chk("burst_px2", {plot, x, gnt1}, {1'b1, 9'd102, 1'b1});
        x1 = 9'd103; last1 = 1'b1;
        tick();
        chk("burst_px3", {plot, x, gnt1, clear_busy}, {1'b1, 9'd103, 1'b0, 1'b1});
        req1 = 1'b0; last1 = 1'b0;
        tick();
        chk("burst_bubble", {plot, clear_busy}, 2'b01);
        tick();
        chk("sweep_first", {plot, x, y, colour, clear_busy}, {1'b1, 9'd0, 8'd0, 3'd6, 1'b1});

        // Abort the sweep by reset once pixel 1000 is on the outputs.
        repeat (1000) tick();
        chk("sweep_px1000", {plot, x, y}, {1'b1, 9'd40, 8'd3});
        reset = 1'b1;
        tick();
        chk("abort_outputs", {plot, clear_busy, clear_done}, 3'b000);
        reset = 1'b0;

        // Requester 0 abandons its burst while requester 1 waits.
        req0 = 1'b1; last0 = 1'b0; x0 = 9'd7; y0 = 8'd8; colour0 = 3'd2;
        req1 = 1'b1; last1 = 1'b1; x1 = 9'd9; y1 = 8'd11; colour1 = 3'd4;
        tick();
        chk("abandon_gnt", {gnt0, gnt1}, 2'b10);
        tick();
        chk("post_reset_plot", {plot, x, y}, {1'b1, 9'd7, 8'd8});
        req0 = 1'b0;
        tick();
        chk("abandon_idle", {gnt0, gnt1}, 2'b00);
        tick();
        chk("abandon_gnt1", {gnt0, gnt1}, 2'b01);
        tick();
        chk("abandon_px1", {plot, x, y}, {1'b1, 9'd9, 8'd11});
        req1 = 1'b0; last1 = 1'b0;
        repeat (3) tick();

        // Full-frame clear with a re-request mid-sweep that must be ignored.
        clear_start = 1'b1; clear_colour = 3'b010;
        tick();
        clear_start = 1'b0;
        chk("full_busy", {clear_busy, plot}, 2'b10);
        k = 0; dones = 0; gaps = 0; done_at = -1;
        for (int c = 0; c < 76900 && k < W * H; c++) begin
            tick();
            clear_start = 1'b0;
            if (plot) begin
                if (k == 0)     chk("full_first", {x, y, colour}, {9'd0, 8'd0, 3'd2});
                if (k == 319)   chk("full_end_line0", {x, y}, {9'd319, 8'd0});
                if (k == 320)   chk("full_wrap", {x, y}, {9'd0, 8'd1});
                if (k == 500) begin
                    clear_start = 1'b1; clear_colour = 3'd7;
                end
                if (k == W * H - 1) begin
                    chk("full_last", {x, y, colour}, {9'd319, 8'd239, 3'd2});
                    chk("full_busy_at_done", clear_busy, 0);
                end
                k++;
            end else if (k > 0) begin
                gaps++;
            end
            if (clear_done) begin
                dones++;
                done_at = k;
            end
        end
        chk("full_pulses", k, W * H);
        chk("full_gaps", gaps, 0);
        chk("full_done_count", dones, 1);
        chk("full_done_aligned", done_at, W * H);
        tick();
        chk("full_after", {plot, clear_busy, clear_done}, 3'b000);

        // Randomized traffic; sweeps are cut short by reset to bound run time.
        for (int c = 0; c < 3000; c++) begin
            tick();
            req0         = ($urandom_range(0, 3) != 0);
            req1         = ($urandom_range(0, 3) != 0);
            last0        = ($urandom_range(0, 3) == 0);
            last1        = ($urandom_range(0, 3) == 0);
            x0           = 9'($urandom_range(0, 511));
            y0           = 8'($urandom_range(0, 255));
            colour0      = 3'($urandom_range(0, 7));
            x1           = 9'($urandom_range(0, 511));
            y1           = 8'($urandom_range(0, 255));
            colour1      = 3'($urandom_range(0, 7));
            clear_start  = ($urandom_range(0, 79) == 0);
            clear_colour = 3'($urandom_range(0, 7));
            reset        = (m_own == 3 && $urandom_range(0, 15) == 0) ||
                           ($urandom_range(0, 499) == 0);
        end
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
